// File: rtl/spr_shp_if.sv
// Sync/DE, config request and status bundle for the SPR sharpness controller.
// master drives syncs and cfg_*; slave (the controller) returns enables, shadows and counters.
interface spr_shp_if #(
  parameter int PIX_W = 13,
  parameter int LIN_W = 12
);
  logic             i_hs;
  logic             i_vs;
  logic             i_de;
  logic             cfg_update;
  logic             cfg_sharp_en;
  logic             cfg_sharp_prt;
  logic [12:0]      cfg_thr_hi;
  logic [12:0]      cfg_thr_lo;
  logic             shp_pre_en;
  logic             shp_en;
  logic             spr_sharp_en;
  logic             spr_sharp_prt;
  logic [12:0]      spr_thr_hi;
  logic [12:0]      spr_thr_lo;
  logic             o_hs;
  logic             o_vs;
  logic             o_de;
  logic             cfg_ack;
  logic             err_thr;
  logic [PIX_W-1:0] pix_cnt;
  logic [LIN_W-1:0] line_cnt;

  modport master (
    output i_hs, i_vs, i_de,
    output cfg_update, cfg_sharp_en, cfg_sharp_prt,
    output cfg_thr_hi, cfg_thr_lo,
    input  shp_pre_en, shp_en,
    input  spr_sharp_en, spr_sharp_prt,
    input  spr_thr_hi, spr_thr_lo,
    input  o_hs, o_vs, o_de,
    input  cfg_ack, err_thr,
    input  pix_cnt, line_cnt
  );

  modport slave (
    input  i_hs, i_vs, i_de,
    input  cfg_update, cfg_sharp_en, cfg_sharp_prt,
    input  cfg_thr_hi, cfg_thr_lo,
    output shp_pre_en, shp_en,
    output spr_sharp_en, spr_sharp_prt,
    output spr_thr_hi, spr_thr_lo,
    output o_hs, o_vs, o_de,
    output cfg_ack, err_thr,
    output pix_cnt, line_cnt
  );
endinterface

// File: rtl/spr_shp_ctrl.sv
// Frame/line sequencer and frame-synchronous config shadow for the SPR sharpness path.
// Ports: clk, rst (sync, active-high), bus (spr_shp_if.slave: syncs/cfg in, enables/shadows/counters out).
module spr_shp_ctrl #(
  parameter int PRE_LAT = 1,
  parameter int SHP_LAT = 1,
  parameter int PIX_W   = 13,
  parameter int LIN_W   = 12
) (
  input  logic     clk,
  input  logic     rst,
  spr_shp_if.slave bus
);

  localparam int SYNC_LAT = 1 + PRE_LAT + SHP_LAT;

  typedef enum logic [1:0] {
    IDLE,
    VSTART,
    LINE_WAIT,
    ACTIVE
  } state_t;

  state_t state;
  state_t state_nx;

  logic             vs_d1;
  logic             de_d1;
  logic             vs_rise;
  logic             run;
  logic             apply;
  logic             thr_bad;
  logic             pending;
  logic             pre_en;
  logic [PRE_LAT-1:0] pre_sr;
  logic [2:0]       sync_sr [SYNC_LAT];
  logic             ack;
  logic             err;
  logic             sh_en;
  logic             sh_prt;
  logic [12:0]      sh_hi;
  logic [12:0]      sh_lo;
  logic [PIX_W-1:0] pix;
  logic [LIN_W-1:0] line;

  assign vs_rise = bus.i_vs & ~vs_d1;
  assign run     = (state != IDLE);
  assign apply   = (state == VSTART) & pending;
  assign thr_bad = (bus.cfg_thr_lo > bus.cfg_thr_hi);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A frame start pre-empts whatever the sequencer was doing.
  always_comb begin
    state_nx = state;
    if (vs_rise) begin
      state_nx = VSTART;
    end else begin
      unique case (state)
        IDLE:      state_nx = IDLE;
        VSTART:    state_nx = LINE_WAIT;
        LINE_WAIT: if (bus.i_de)  state_nx = ACTIVE;
        ACTIVE:    if (!bus.i_de) state_nx = LINE_WAIT;
        default:   state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d1  <= 1'b0;
      de_d1  <= 1'b0;
      pre_en <= 1'b0;
      pre_sr <= '0;
      for (int i = 0; i < SYNC_LAT; i++) sync_sr[i] <= 3'b000;
    end else begin
      vs_d1  <= bus.i_vs;
      de_d1  <= bus.i_de;
      pre_en <= bus.i_de & run;
      pre_sr[0] <= pre_en;
      for (int i = 1; i < PRE_LAT; i++) pre_sr[i] <= pre_sr[i-1];
      sync_sr[0] <= {bus.i_hs, bus.i_vs, bus.i_de};
      for (int i = 1; i < SYNC_LAT; i++) sync_sr[i] <= sync_sr[i-1];
    end
  end

  // A request landing in the apply cycle itself is kept for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      sh_en   <= 1'b0;
      sh_prt  <= 1'b0;
      sh_hi   <= 13'h1FFF;
      sh_lo   <= 13'h0000;
    end else begin
      ack <= apply;
      if (apply)               pending <= bus.cfg_update;
      else if (bus.cfg_update) pending <= 1'b1;
      if (apply) begin
        sh_en  <= bus.cfg_sharp_en;
        sh_prt <= bus.cfg_sharp_prt;
        sh_hi  <= bus.cfg_thr_hi;
        if (thr_bad) begin
          sh_lo <= bus.cfg_thr_hi;
          err   <= 1'b1;
        end else begin
          sh_lo <= bus.cfg_thr_lo;
          err   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix  <= '0;
      line <= '0;
    end else begin
      if (run && bus.i_de) begin
        if (!de_d1)      pix <= '0;
        else if (~&pix)  pix <= pix + 1'b1;
      end
      if (state == VSTART)
        line <= '0;
      else if (run && !bus.i_de && de_d1 && ~&line)
        line <= line + 1'b1;
    end
  end

  assign bus.shp_pre_en    = pre_en;
  assign bus.shp_en        = pre_sr[PRE_LAT-1];
  assign bus.o_hs          = sync_sr[SYNC_LAT-1][2];
  assign bus.o_vs          = sync_sr[SYNC_LAT-1][1];
  assign bus.o_de          = sync_sr[SYNC_LAT-1][0];
  assign bus.cfg_ack       = ack;
  assign bus.err_thr       = err;
  assign bus.spr_sharp_en  = sh_en;
  assign bus.spr_sharp_prt = sh_prt;
  assign bus.spr_thr_hi    = sh_hi;
  assign bus.spr_thr_lo    = sh_lo;
  assign bus.pix_cnt       = pix;
  assign bus.line_cnt      = line;

endmodule

// File: doc/spr_shp_ctrl.md
Name: spr_shp_ctrl

Overview:
- Frame/line sequencer and configuration shadow for the SPR sharpness datapath.
- It sits in front of the three-channel preprocess and sharpness pipeline.
- From incoming sync/DE it generates the stage enables `shp_pre_en` and `shp_en`, plus delay-matched output syncs.
- It latches the sharpness configuration into frame-synchronous shadow registers, so thresholds and modes never change mid-frame.

Parameters:
- PRE_LAT, 1: latency in clk cycles of the preprocess stage.
- SHP_LAT, 1: latency in clk cycles of the sharpness stage.
- PIX_W, 13: width of the pixel counter.
- LIN_W, 12: width of the line counter.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- i_hs  in  1  horizontal sync, active-high
- i_vs  in  1  vertical sync, active-high; rising edge marks frame start
- i_de  in  1  active-pixel data enable
- cfg_update  in  1  one-cycle request to apply cfg_* at the next frame start
- cfg_sharp_en  in  1  requested sharpness enable
- cfg_sharp_prt  in  1  requested sharpness protect mode
- cfg_thr_hi  in  13  requested high threshold
- cfg_thr_lo  in  13  requested low threshold
- shp_pre_en  out  1  preprocess stage enable
- shp_en  out  1  sharpness stage enable
- spr_sharp_en  out  1  shadowed enable
- spr_sharp_prt  out  1  shadowed protect mode
- spr_thr_hi  out  13  shadowed high threshold
- spr_thr_lo  out  13  shadowed low threshold
- o_hs  out  1  i_hs delayed to match the datapath
- o_vs  out  1  i_vs delayed to match the datapath
- o_de  out  1  i_de delayed to match the datapath
- cfg_ack  out  1  one-cycle pulse when a pending config is applied
- err_thr  out  1  sticky flag: last applied config had lo > hi
- pix_cnt  out  PIX_W  active pixel index in the current line
- line_cnt  out  LIN_W  active line index in the current frame

Behaviour:
- Reset (rst=1 at a clk edge): every register and output clears in that cycle:
  - FSM=IDLE, pending=0, all enables, syncs, counters, cfg_ack and err_thr = 0.
  - spr_sharp_en=0, spr_sharp_prt=0, spr_thr_hi=13'h1FFF, spr_thr_lo=0.
  - Reset mid-frame aborts the frame; enables are low on the next cycle.
- vs_rise = i_vs & ~i_vs_d1, with i_vs_d1 registered.
- FSM states IDLE, VSTART, LINE_WAIT, ACTIVE.
  - vs_rise in any state -> VSTART (this aborts any frame in progress).
  - VSTART lasts one cycle, then -> LINE_WAIT.
  - LINE_WAIT: i_de=1 -> ACTIVE.
  - ACTIVE: i_de=0 -> LINE_WAIT.
  - IDLE exits only on vs_rise.
- Enable timing:
  - shp_pre_en(t+1) = i_de(t) & (state != IDLE); latency 1.
  - shp_en = shp_pre_en delayed PRE_LAT cycles.
  - o_hs, o_vs, o_de = inputs delayed 1+PRE_LAT+SHP_LAT cycles; not gated by state.
  - All delay-line stages reset to 0.
- Config handshake:
  - cfg_update=1 sets pending; further pulses overwrite nothing (cfg_* are sampled only at apply).
  - In the VSTART cycle with pending=1: shadow registers load from cfg_*, pending clears, and cfg_ack pulses 1 cycle. All of these take effect on the clk edge ending VSTART.
  - cfg_update asserted in the same cycle as VSTART is not applied; pending stays/becomes 1 and applies at the following frame.
  - pending=0 at VSTART: shadow unchanged, no ack.
- Threshold check at apply:
  - If cfg_thr_lo > cfg_thr_hi: load spr_thr_hi = spr_thr_lo = cfg_thr_hi and set err_thr=1.
  - Otherwise load both values unchanged and clear err_thr.
  - Equality is legal.
- Counters:
  - pix_cnt: 0 on the first DE cycle of a line, +1 per DE cycle, saturating at all-ones; holds during blanking.
  - line_cnt: 0 at VSTART, +1 on each i_de falling edge, saturating at all-ones.
  - Counters hold in IDLE.

Test Plan:
- Reset, then vs_rise with no cfg_update -> spr_thr_hi=8191, spr_thr_lo=0, spr_sharp_en=0, cfg_ack never pulses.
- cfg_update with hi=800, lo=200, en=1 mid-frame -> outputs unchanged until next vs_rise; cfg_ack one cycle after vs_rise (edge ending VSTART); then hi=800, lo=200, en=1, err_thr=0.
- cfg_update with lo=900, hi=300, then frame start -> hi=lo=300, err_thr=1; a later valid config (hi=500, lo=100) clears err_thr.
- Line with 16 DE cycles, PRE_LAT=2, SHP_LAT=3 -> shp_pre_en 16 cycles starting 1 cycle after DE; shp_en starts 3 cycles after DE; o_de starts 6 cycles after DE; pix_cnt ends at 15; line_cnt increments to 1.
- cfg_update in the same cycle as VSTART -> no ack this frame; applied with ack at the next vs_rise.
- rst asserted during ACTIVE -> next cycle shp_pre_en=0, counters 0, FSM=IDLE; enables stay 0 despite i_de until a new vs_rise.
